// File: rtl/tetris_board_renderer.sv
// rtl/tetris_board_renderer.sv - 2-stage playfield renderer with line-clear flash and mode shading
// S1 registers cell coordinates and region flags, S2 resolves the colour.
module tetris_board_renderer #(
   parameter int ROWS          = 20,
   parameter int COLS          = 10,
   parameter int CELL          = 24,
   parameter int ORIGIN_X      = 100,
   parameter int ORIGIN_Y      = 0,
   parameter int ACTIVE_H      = 480,
   parameter int FLASH_FRAMES  = 8,
   parameter int FLASH_TOGGLES = 6
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [9:0]             DrawX,
   input  logic [9:0]             DrawY,
   input  logic                   vde,
   input  logic [ROWS*COLS*3-1:0] grid,
   input  logic [1:0]             mode,
   input  logic [ROWS-1:0]        clear_mask,
   input  logic                   clear_start,
   output logic                   in_board,
   output logic [3:0]             Red,
   output logic [3:0]             Green,
   output logic [3:0]             Blue,
   output logic                   vde_out,
   output logic                   clear_busy,
   output logic                   clear_done
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int FW    = $clog2(FLASH_FRAMES + 1);
   localparam int TW    = $clog2(FLASH_TOGGLES + 1);
   localparam bit BOTTOM_EN = (ORIGIN_Y + ROWS * CELL) < ACTIVE_H;

   localparam logic [1:0] MODE_START = 2'd0;
   localparam logic [1:0] MODE_PAUSE = 2'd2;
   localparam logic [1:0] MODE_OVER  = 2'd3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FLASH = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Signed offsets keep pixels left of / above the origin from wrapping into the board
   logic signed [10:0] w_dx, w_dy;
   logic w_x_in, w_y_in, w_x_edge, w_y_bottom, w_inside, w_border, w_line;

   assign w_dx       = $signed({1'b0, DrawX}) - $signed(11'(ORIGIN_X));
   assign w_dy       = $signed({1'b0, DrawY}) - $signed(11'(ORIGIN_Y));
   assign w_x_in     = !w_dx[10] && (w_dx[9:0] < 10'(COLS * CELL));
   assign w_y_in     = !w_dy[10] && (w_dy[9:0] < 10'(ROWS * CELL));
   assign w_x_edge   = (w_dx == -11'sd1) || (w_dx == $signed(11'(COLS * CELL)));
   assign w_y_bottom = BOTTOM_EN && (w_dy == $signed(11'(ROWS * CELL)));
   assign w_inside   = w_x_in && w_y_in;
   assign w_border   = (w_x_edge && (w_y_in || w_y_bottom)) || (w_y_bottom && w_x_in);
   assign w_line     = ((w_dx[9:0] % 10'(CELL)) == 10'd0) || ((w_dy[9:0] % 10'(CELL)) == 10'd0);

   logic             r_s1_inside, r_s1_border, r_s1_line, r_s1_vde;
   logic [ROW_W-1:0] r_s1_row;
   logic [COL_W-1:0] r_s1_col;
   logic [1:0]       r_s1_mode;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_s1_inside <= 1'b0;
         r_s1_border <= 1'b0;
         r_s1_line   <= 1'b0;
         r_s1_vde    <= 1'b0;
         r_s1_row    <= '0;
         r_s1_col    <= '0;
         r_s1_mode   <= 2'd0;
      end else begin
         r_s1_inside <= w_inside;
         r_s1_border <= w_border;
         r_s1_line   <= w_line;
         r_s1_vde    <= vde;
         r_s1_row    <= w_inside ? ROW_W'(w_dy[9:0] / 10'(CELL)) : '0;
         r_s1_col    <= w_inside ? COL_W'(w_dx[9:0] / 10'(CELL)) : '0;
         r_s1_mode   <= mode;
      end
   end

   logic w_tick_cond, w_frame_tick, r_tick_prev;
   assign w_tick_cond  = (DrawY == 10'(ACTIVE_H)) && (DrawX == 10'd0);
   assign w_frame_tick = w_tick_cond && !r_tick_prev;

   logic [1:0]      r_state;
   logic            r_phase, r_clear_done;
   logic [FW-1:0]   r_frame_cnt, r_fade_frames;
   logic [TW-1:0]   r_toggle_cnt;
   logic [ROWS-1:0] r_mask;
   logic [3:0]      r_fade;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_tick_prev  <= 1'b0;
         r_state      <= ST_IDLE;
         r_phase      <= 1'b0;
         r_frame_cnt  <= '0;
         r_toggle_cnt <= '0;
         r_mask       <= '0;
         r_clear_done <= 1'b0;
      end else begin
         r_tick_prev  <= w_tick_cond;
         r_clear_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (clear_start) begin
                  if (clear_mask != '0) begin
                     r_mask       <= clear_mask;
                     r_phase      <= 1'b1;
                     r_frame_cnt  <= '0;
                     r_toggle_cnt <= '0;
                     r_state      <= ST_FLASH;
                  end else begin
                     r_clear_done <= 1'b1;
                  end
               end
            end
            ST_FLASH: begin
               if (w_frame_tick) begin
                  if (r_frame_cnt == FW'(FLASH_FRAMES - 1)) begin
                     r_frame_cnt  <= '0;
                     r_phase      <= ~r_phase;
                     r_toggle_cnt <= r_toggle_cnt + 1'b1;
                     if (r_toggle_cnt == TW'(FLASH_TOGGLES - 1)) begin
                        r_state      <= ST_DONE;
                        r_clear_done <= 1'b1;
                     end
                  end else begin
                     r_frame_cnt <= r_frame_cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_mask       <= '0;
               r_phase      <= 1'b0;
               r_toggle_cnt <= '0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign clear_busy = (r_state == ST_FLASH) || (r_state == ST_DONE);
   assign clear_done = r_clear_done;

   always_ff @(posedge Clk) begin
      if (Reset || (mode != MODE_OVER)) begin
         r_fade        <= 4'd0;
         r_fade_frames <= '0;
      end else if (w_frame_tick) begin
         if (r_fade_frames == FW'(FLASH_FRAMES - 1)) begin
            r_fade_frames <= '0;
            if (r_fade != 4'd15) r_fade <= r_fade + 4'd1;
         end else begin
            r_fade_frames <= r_fade_frames + 1'b1;
         end
      end
   end

   function automatic logic [3:0] fade_sub(input logic [3:0] ch, input logic [3:0] f);
      return (ch > f) ? (ch - f) : 4'd0;
   endfunction

   logic [15:0] w_cell_idx, w_bit_idx;
   logic [2:0]  w_code;
   logic [11:0] w_pal, w_rgb;

   assign w_cell_idx = 16'(r_s1_row) * 16'(COLS) + 16'(r_s1_col);
   assign w_bit_idx  = w_cell_idx * 16'd3;

   always_comb begin
      w_code = grid[w_bit_idx +: 3];
      case (w_code)
         3'd0:    w_pal = 12'h007;
         3'd1:    w_pal = 12'h0FF;
         3'd2:    w_pal = 12'h00F;
         3'd3:    w_pal = 12'hF80;
         3'd4:    w_pal = 12'hFF0;
         3'd5:    w_pal = 12'h0F0;
         3'd6:    w_pal = 12'h80F;
         default: w_pal = 12'hF00;
      endcase
      w_rgb = 12'h104;
      if (r_s1_inside) begin
         if (r_s1_line)
            w_rgb = 12'h02F;
         else if ((r_state == ST_FLASH) && r_phase && r_mask[r_s1_row])
            w_rgb = 12'hFFF;
         else
            w_rgb = w_pal;
         case (r_s1_mode)
            MODE_START: if (!r_s1_line) w_rgb = 12'h007;
            MODE_PAUSE: w_rgb = {1'b0, w_rgb[11:9], 1'b0, w_rgb[7:5], 1'b0, w_rgb[3:1]};
            MODE_OVER:  w_rgb = {fade_sub(w_rgb[11:8], r_fade), fade_sub(w_rgb[7:4], r_fade),
                                 fade_sub(w_rgb[3:0], r_fade)};
            default: ;
         endcase
      end else if (r_s1_border) begin
         w_rgb = 12'h08F;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         in_board <= 1'b0;
         vde_out  <= 1'b0;
         Red      <= 4'd0;
         Green    <= 4'd0;
         Blue     <= 4'd0;
      end else begin
         in_board             <= r_s1_inside || r_s1_border;
         vde_out              <= r_s1_vde;
         {Red, Green, Blue}   <= r_s1_vde ? w_rgb : 12'h000;
      end
   end

endmodule

// File: tb/tb_tetris_board_renderer.sv
// tb/tb_tetris_board_renderer.sv - table-driven checks of rendering, clear animation and mode shading
module tb_tetris_board_renderer;

   localparam int ROWS = 20;
   localparam int COLS = 10;

   logic                   Clk = 1'b0;
   logic                   Reset;
   logic [9:0]             DrawX, DrawY;
   logic                   vde;
   logic [ROWS*COLS*3-1:0] grid;
   logic [1:0]             mode;
   logic [ROWS-1:0]        clear_mask;
   logic                   clear_start;
   logic                   in_board, vde_out, clear_busy, clear_done;
   logic [3:0]             Red, Green, Blue;

   always #5 Clk = ~Clk;

   tetris_board_renderer dut (
      .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .vde(vde), .grid(grid),
      .mode(mode), .clear_mask(clear_mask), .clear_start(clear_start), .in_board(in_board),
      .Red(Red), .Green(Green), .Blue(Blue), .vde_out(vde_out), .clear_busy(clear_busy),
      .clear_done(clear_done)
   );

   typedef struct {
      string       name;
      logic [1:0]  m;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        v;
      logic [11:0] rgb;
      logic        inb;
      logic        vo;
   } vec_t;

   localparam logic [1:0] M_START = 2'd0, M_PLAY = 2'd1, M_PAUSE = 2'd2, M_OVER = 2'd3;

   int checks = 0;
   int errors = 0;
   int ticks = 0;
   int done_cnt = 0;
   int done_at = -1;
   vec_t vecs[$];

   always @(negedge Clk) begin
      if (clear_done) begin
         done_cnt = done_cnt + 1;
         done_at  = ticks;
      end
   end

   function automatic vec_t mk(string n, logic [1:0] m, int x, int y, logic v,
                               logic [11:0] rgb, logic inb, logic vo);
      vec_t r;
      r.name = n; r.m = m; r.x = 10'(x); r.y = 10'(y); r.v = v;
      r.rgb = rgb; r.inb = inb; r.vo = vo;
      return r;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic set_cell(input int r, input int c, input logic [2:0] v);
      grid[(r*COLS+c)*3 +: 3] = v;
   endtask

   task automatic frame_tick();
      DrawX = 10'd0;
      DrawY = 10'd480;
      step();
      ticks = ticks + 1;
      DrawY = 10'd0;
      step();
   endtask

   // Pixel is held for one cycle only, so a wrong pipeline depth shows the filler colour
   task automatic probe(input string nm, input int x, input int y, input logic [11:0] exp);
      DrawX = 10'(x);
      DrawY = 10'(y);
      vde   = 1'b1;
      step();
      DrawX = 10'd0;
      DrawY = 10'd0;
      step();
      chk(nm, {20'd0, Red, Green, Blue}, {20'd0, exp});
   endtask

   initial begin
      int d0;
      Reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; vde = 1'b0; grid = '0;
      mode = M_PLAY; clear_mask = '0; clear_start = 1'b0;
      set_cell(0, 0, 3'd3);
      set_cell(0, 1, 3'd1);
      set_cell(19, 9, 3'd7);

      vecs.push_back(mk("p_cell",  M_PLAY,  101,   1, 1'b1, 12'hF80, 1'b1, 1'b1));
      vecs.push_back(mk("p_bndx",  M_PLAY,  100,   1, 1'b1, 12'h02F, 1'b1, 1'b1));
      vecs.push_back(mk("p_lbrd",  M_PLAY,   99,   1, 1'b1, 12'h08F, 1'b1, 1'b1));
      vecs.push_back(mk("p_out",   M_PLAY,   50,   1, 1'b1, 12'h104, 1'b0, 1'b1));
      vecs.push_back(mk("p_vde0",  M_PLAY,  101,   1, 1'b0, 12'h000, 1'b1, 1'b0));
      vecs.push_back(mk("p_last",  M_PLAY,  331, 457, 1'b1, 12'hF00, 1'b1, 1'b1));
      vecs.push_back(mk("p_rbrd",  M_PLAY,  340,   1, 1'b1, 12'h08F, 1'b1, 1'b1));
      vecs.push_back(mk("p_rout",  M_PLAY,  341,   1, 1'b1, 12'h104, 1'b0, 1'b1));
      vecs.push_back(mk("p_cyan",  M_PLAY,  125,   2, 1'b1, 12'h0FF, 1'b1, 1'b1));
      vecs.push_back(mk("p_bndy",  M_PLAY,  101,  24, 1'b1, 12'h02F, 1'b1, 1'b1));
      vecs.push_back(mk("p_empty", M_PLAY,  150,  30, 1'b1, 12'h007, 1'b1, 1'b1));
      vecs.push_back(mk("p_r19c0", M_PLAY,  101, 479, 1'b1, 12'h007, 1'b1, 1'b1));
      vecs.push_back(mk("p_nobot", M_PLAY,   99, 480, 1'b1, 12'h104, 1'b0, 1'b1));
      vecs.push_back(mk("z_cell",  M_PAUSE, 101,   1, 1'b1, 12'h740, 1'b1, 1'b1));
      vecs.push_back(mk("z_bnd",   M_PAUSE, 100,   1, 1'b1, 12'h017, 1'b1, 1'b1));
      vecs.push_back(mk("z_brd",   M_PAUSE,  99,   1, 1'b1, 12'h08F, 1'b1, 1'b1));
      vecs.push_back(mk("z_out",   M_PAUSE,  50,   1, 1'b1, 12'h104, 1'b0, 1'b1));
      vecs.push_back(mk("s_cell",  M_START, 101,   1, 1'b1, 12'h007, 1'b1, 1'b1));
      vecs.push_back(mk("s_bnd",   M_START, 100,   1, 1'b1, 12'h02F, 1'b1, 1'b1));
      vecs.push_back(mk("s_last",  M_START, 331, 457, 1'b1, 12'h007, 1'b1, 1'b1));

      step();
      step();
      chk("rst_rgb",  {20'd0, Red, Green, Blue}, 32'h0);
      chk("rst_inb",  {31'd0, in_board}, 32'd0);
      chk("rst_vde",  {31'd0, vde_out}, 32'd0);
      chk("rst_busy", {31'd0, clear_busy}, 32'd0);
      chk("rst_done", {31'd0, clear_done}, 32'd0);
      Reset = 1'b0;
      step();

      foreach (vecs[i]) begin
         mode  = vecs[i].m;
         DrawX = vecs[i].x;
         DrawY = vecs[i].y;
         vde   = vecs[i].v;
         step();
         DrawX = 10'd0;
         DrawY = 10'd0;
         vde   = 1'b1;
         step();
         chk({vecs[i].name, "_rgb"}, {20'd0, Red, Green, Blue}, {20'd0, vecs[i].rgb});
         chk({vecs[i].name, "_inb"}, {31'd0, in_board}, {31'd0, vecs[i].inb});
         chk({vecs[i].name, "_vde"}, {31'd0, vde_out}, {31'd0, vecs[i].vo});
      end

      // Full clear animation on row 19, with an ignored restart request mid-way
      mode = M_PLAY;
      ticks = 0;
      d0 = done_cnt;
      clear_mask = 20'h80000;
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      clear_mask = '0;
      chk("cl_busy0", {31'd0, clear_busy}, 32'd1);
      probe("cl_flash0", 331, 457, 12'hFFF);
      probe("cl_bnd0", 316, 457, 12'h02F);
      probe("cl_row0", 101, 1, 12'hF80);
      for (int t = 1; t <= 48; t++) begin
         frame_tick();
         if (t < 48) chk($sformatf("cl_busy_t%0d", t), {31'd0, clear_busy}, 32'd1);
         if (t == 20) begin
            clear_mask = 20'h00001;
            clear_start = 1'b1;
            step();
            clear_start = 1'b0;
            clear_mask = '0;
         end
         if ((t % 4) == 2 && t < 48) begin
            probe($sformatf("cl_r19_t%0d", t), 331, 457, (((t / 8) % 2) == 0) ? 12'hFFF : 12'hF00);
            probe($sformatf("cl_r0_t%0d", t), 101, 1, 12'hF80);
         end
      end
      chk("cl_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("cl_done_at", 32'(done_at), 32'd48);
      step();
      chk("cl_busy_end", {31'd0, clear_busy}, 32'd0);
      probe("cl_after", 331, 457, 12'hF00);

      // Empty mask completes immediately
      d0 = done_cnt;
      clear_mask = '0;
      clear_start = 1'b1;
      step();
      chk("z_done", {31'd0, clear_done}, 32'd1);
      chk("z_busy", {31'd0, clear_busy}, 32'd0);
      clear_start = 1'b0;
      step();
      chk("z_done_off", {31'd0, clear_done}, 32'd0);
      chk("z_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Reset during an animation abandons it silently
      ticks = 0;
      d0 = done_cnt;
      clear_mask = 20'h80000;
      clear_start = 1'b1;
      step();
      clear_start = 1'b0;
      for (int t = 0; t < 20; t++) frame_tick();
      chk("rm_busy", {31'd0, clear_busy}, 32'd1);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      chk("rm_busy_rst", {31'd0, clear_busy}, 32'd0);
      chk("rm_done_rst", {31'd0, clear_done}, 32'd0);
      for (int t = 0; t < 30; t++) frame_tick();
      chk("rm_no_done", 32'(done_cnt - d0), 32'd0);
      probe("rm_render", 331, 457, 12'hF00);

      // Game-over fade
      mode = M_OVER;
      step();
      probe("go_f0", 125, 2, 12'h0FF);
      for (int t = 0; t < 8; t++) frame_tick();
      probe("go_f1", 125, 2, 12'h0EE);
      for (int t = 0; t < 8; t++) frame_tick();
      probe("go_f2", 125, 2, 12'h0DD);
      probe("go_brd", 99, 1, 12'h08F);
      for (int t = 0; t < 104; t++) frame_tick();
      probe("go_f15", 125, 2, 12'h000);
      for (int t = 0; t < 16; t++) frame_tick();
      probe("go_sat", 101, 1, 12'h000);
      mode = M_PLAY;
      step();
      probe("go_play", 125, 2, 12'h0FF);
      mode = M_OVER;
      step();
      probe("go_reset_fade", 125, 2, 12'h0FF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tetris_board_renderer.md
Name: tetris_board_renderer

Overview:
Registered, parametrised successor to the combinational board colour mapper. Converts the current beam position plus the packed playfield grid into 12-bit RGB with a fixed 2-cycle pipeline. It also owns the line-clear flash animation and the per-mode (start/play/pause/game-over) board shading. It sits between the VGA/HDMI timing generator and the text/sign overlay mux, and renders the playfield region only.

Parameters:
ROWS, 20, playfield rows (row 0 = top)
COLS, 10, playfield columns (col 0 = left)
CELL, 24, cell size in pixels (square)
ORIGIN_X, 100, left pixel of board
ORIGIN_Y, 0, top pixel of board
ACTIVE_H, 480, first non-visible line; frame tick reference
FLASH_FRAMES, 8, frames per flash phase / fade step
FLASH_TOGGLES, 6, phase toggles per clear animation

Ports:
Clk  in  1  pixel clock; DrawX/DrawY advance one pixel per cycle
Reset  in  1  synchronous, active-high
DrawX  in  10  beam column
DrawY  in  10  beam row
vde  in  1  active-video flag aligned with DrawX/DrawY
grid  in  ROWS*COLS*3  packed cell colour codes; cell (r,c) at bits [(r*COLS+c)*3 +: 3]
mode  in  2  0=START, 1=PLAY, 2=PAUSE, 3=GAMEOVER
clear_mask  in  ROWS  rows to flash, sampled on clear_start
clear_start  in  1  one-cycle request to start the clear animation
in_board  out  1  pixel lies in the board rectangle or its border (pipelined)
Red, Green, Blue  out  4 each  registered colour
vde_out  out  1  vde delayed 2 cycles
clear_busy  out  1  high while the animation runs
clear_done  out  1  one-cycle pulse when the animation ends

Behaviour:
- Reset: all outputs 0, FSM IDLE, phase 0, frame counter 0, fade 0, latched mask 0.
- Pipeline, latency exactly 2 cycles:
  - S1 registers cell_r=(DrawY-ORIGIN_Y)/CELL, cell_c=(DrawX-ORIGIN_X)/CELL, region flags, and the cell-boundary flag ((DrawX-ORIGIN_X)%CELL==0 or (DrawY-ORIGIN_Y)%CELL==0).
  - S2 indexes the grid, applies the palette and mode, then registers RGB, in_board and vde_out.
- Regions:
  - Inside board: ORIGIN_X<=DrawX<ORIGIN_X+COLS*CELL and ORIGIN_Y<=DrawY<ORIGIN_Y+ROWS*CELL.
  - Border: columns ORIGIN_X-1 and ORIGIN_X+COLS*CELL, and row ORIGIN_Y+ROWS*CELL (only where that row is < ACTIVE_H).
  - Outside: RGB=0x104, in_board=0.
- Colours:
  - Border 0x08F. Cell boundary 0x02F.
  - Palette: 0=0x007 (empty), 1=0x0FF, 2=0x00F, 3=0xF80, 4=0xFF0, 5=0x0F0, 6=0x80F, 7=0xF00.
- vde_out=0 forces RGB=0; in_board is still computed.
- Frame tick: one-cycle pulse on the first cycle with DrawY==ACTIVE_H and DrawX==0.
- Clear FSM:
  - IDLE: on clear_start with mask≠0, latch the mask, phase=1, frame counter=0, go FLASH. On clear_start with mask==0, pulse clear_done next cycle and stay IDLE.
  - FLASH: each frame tick increments the frame counter. At FLASH_FRAMES it clears the counter, toggles phase and increments the toggle count. When the toggle count reaches FLASH_TOGGLES, go DONE.
  - DONE: clear_done=1 for one cycle, then IDLE; latched mask is cleared.
  - clear_busy=1 in FLASH and DONE. clear_start is ignored outside IDLE.
- Flash render: in FLASH with phase=1, non-boundary cells of latched rows draw 0xFFF; boundaries are unchanged.
- Modes (board interior only; border and outside are unaffected):
  - START: cells draw 0x007 regardless of grid. Boundaries are still drawn.
  - PLAY: normal rendering.
  - PAUSE: each channel of every cell and boundary colour is shifted right by 1.
  - GAMEOVER: fade counter 0..15 increments every FLASH_FRAMES frame ticks and saturates at 15. Each channel = max(channel-fade, 0). Leaving GAMEOVER resets fade to 0 next cycle.
- A mode change takes effect for pixels entering S1 that cycle; there is no frame alignment.
- Reset mid-animation: FSM returns to IDLE, no clear_done pulse.
- Arithmetic: offsets use 11-bit signed intermediates so DrawX<ORIGIN_X never aliases into the board.

Test Plan:
- Reset, mode=PLAY, cell (0,0)=3, drive DrawX=101, DrawY=1, vde=1 -> two cycles later RGB=0xF80, in_board=1, vde_out=1; DrawX=100 -> 0x02F; DrawX=99 -> 0x08F; DrawX=50 -> 0x104, in_board=0.
- vde=0 at DrawX=101 -> RGB=0x000 two cycles later; cell (19,9)=7 at DrawX=331, DrawY=457 -> 0xF00.
- clear_mask=row 19 only, clear_start pulse, run full frames -> row-19 cells alternate 0xFFF and their palette colour every 8 frames. clear_done pulses once after 48 frame ticks; clear_busy=1 throughout; a second clear_start mid-animation has no effect.
- clear_start with mask=0 -> clear_done one cycle later, clear_busy stays 0. Reset asserted at frame 20 of an animation -> IDLE, no clear_done.
- mode=PAUSE with cell colour 0xF80 -> 0x740; mode=START -> 0x007 regardless of grid.
- mode=GAMEOVER, cell 0x0FF -> after 8 frame ticks 0x0EE; after ≥120 frame ticks 0x000 (saturated); switch to PLAY -> 0x0FF.
